if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the MIPS pipeline: owns the PC register, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the load-use hazard unit's targets. It obeys that unit's `pc__load` / `IFID__Ld` stall controls and the branch/jump redirects resolved in ID. A taken redirect flushes IF/ID to a bubble; there is no delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0000: instruction word placed in IF/ID for a bubble.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `pc__load` input 1: from hazard unit; 1 = PC may advance.
- `IFID__Ld` input 1: from hazard unit; 1 = IF/ID may load.
- `branch__taken` input 1: taken branch resolved in ID.
- `branch__target` input 32: branch target.
- `jump` input 1: jump in ID.
- `jump__target` input 32: jump target.
- `imem__req` output 1: fetch request.
- `imem__addr` output 32: fetch address, word aligned.
- `imem__ack` input 1: request completes this cycle.
- `imem__rdata` input 32: instruction, valid when `imem__ack`=1.
- `IFID__inst` output 32: registered instruction to ID.
- `IFID__pc4` output 32: registered PC+4 of that instruction.
- `IFID__valid` output 1: 1 = IF/ID holds a real instruction.
- `fetch__busy` output 1: request outstanding and not acked this cycle.

## Operation
- `advance` = `pc__load` & `IFID__Ld`. Any other combination is a stall: PC and IF/ID hold.
- `redirect` = `advance` & (`branch__taken` | `jump`). Target is `branch__target` if `branch__taken`, else `jump__target`. Branch has priority if both are set. A redirect with `advance`=0 is ignored; ID re-presents it.
- A bubble is IF/ID <= {`NOP`, 32'h0, valid 0}.

FSM states:
- **S_IDLE**
  - Entered by reset; `imem__req`=0.
  - Goes to S_FETCH unconditionally on the next edge.
- **S_FETCH**
  - Drives `imem__req`=1 and `imem__addr`=pc. Address is held stable until ack.
  - Redirect while no ack: set `kill`=1 and `kill_pc`=target. IF/ID <= bubble. State stays S_FETCH.
  - Ack with `kill`=1 or redirect this cycle: discard `imem__rdata`. pc <= target (redirect this cycle takes precedence over `kill_pc`). Clear `kill`. IF/ID <= bubble if `IFID__Ld`. State stays S_FETCH.
  - Ack with `advance` and no kill: IF/ID <= {`imem__rdata`, pc+4, 1}. pc <= pc+4. State stays S_FETCH.
  - Ack without `advance`: buf <= `imem__rdata`. IF/ID holds. State goes to S_HOLD.
  - No ack, `advance`, no redirect: IF/ID <= bubble (fetch-latency bubble).
  - No ack, no `advance`: IF/ID holds.
- **S_HOLD**
  - `imem__req`=0; a fetched instruction is parked in buf.
  - `advance` and redirect: discard buf. pc <= target. IF/ID <= bubble. Go to S_FETCH.
  - `advance` only: IF/ID <= {buf, pc+4, 1}. pc <= pc+4. Go to S_FETCH.
  - Otherwise: hold.
- `fetch__busy` = (state==S_FETCH) & ~`imem__ack`.
- Arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

## Timing
- Reset (async, on `rst`=0): pc=`RESET_PC`, state=S_IDLE, `kill`=0, buf=0, `IFID__inst`=`NOP`, `IFID__pc4`=0, `IFID__valid`=0, `imem__req`=0, `imem__addr`=`RESET_PC`, `fetch__busy`=0.
- Reset asserted mid-request abandons the request. Memory must tolerate `imem__req` dropping before ack.
- First request is issued in the cycle after the first rising edge with `rst`=1.
- With zero-wait memory (ack in the same cycle as req) and no stalls, throughput is one instruction per cycle. An instruction appears on IF/ID one edge after its ack.
- Redirect penalty: exactly one IF/ID bubble. The target's request starts the cycle after the redirect edge.
- A one-cycle hazard stall during a fetch loses no instruction: it is parked in S_HOLD and issued on release.
- `imem__rdata` is sampled only on edges where `imem__ack`=1 and state is S_FETCH. An ack in S_IDLE/S_HOLD is ignored.

## Test plan
- Reset, then ack every cycle, no stalls → `imem__addr` 0,4,8,12; `IFID__inst` follows rdata one cycle later; `IFID__pc4` 4,8,12; `IFID__valid`=1 from the second edge onward.
- Hold `pc__load`=`IFID__Ld`=0 for 2 cycles while ack arrives for addr 8 (rdata 32'h8C22_0004) → S_HOLD, `imem__req`=0, IF/ID unchanged; on release, `IFID__inst`=32'h8C22_0004, `IFID__pc4`=12, next `imem__addr`=12.
- `branch__taken`=1 with target 32'h40 while `advance`=1 → next IF/ID is a bubble (`NOP`, valid 0), next `imem__addr`=32'h40, then `IFID__pc4`=32'h44.
- Memory latency 3 cycles; `jump` to 32'h100 in cycle 1 of the wait → the acked word is discarded, `imem__addr` stays constant until ack, then becomes 32'h100; no valid IF/ID entry from the old address.
- Reset 32'hFFFF_FFFC via `RESET_PC`, ack immediately → `IFID__pc4`=0, next `imem__addr`=0; assert `rst`=0 mid-request → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: hazard controls, ID redirects, imem req/ack and the IF/ID register.
interface if_stage_if;
   localparam int unsigned W = 32;

   logic         pc__load;
   logic         IFID__Ld;
   logic         branch__taken;
   logic [W-1:0] branch__target;
   logic         jump;
   logic [W-1:0] jump__target;
   logic         imem__req;
   logic [W-1:0] imem__addr;
   logic         imem__ack;
   logic [W-1:0] imem__rdata;
   logic [W-1:0] IFID__inst;
   logic [W-1:0] IFID__pc4;
   logic         IFID__valid;
   logic         fetch__busy;

   modport master (
      input  pc__load, IFID__Ld, branch__taken, branch__target, jump, jump__target,
      input  imem__ack, imem__rdata,
      output imem__req, imem__addr, IFID__inst, IFID__pc4, IFID__valid, fetch__busy
   );

   modport slave (
      output pc__load, IFID__Ld, branch__taken, branch__target, jump, jump__target,
      output imem__ack, imem__rdata,
      input  imem__req, imem__addr, IFID__inst, IFID__pc4, IFID__valid, fetch__busy
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over imem req/ack and drives IF/ID.
// Redirects from ID flush IF/ID to a bubble; hazard stalls park an acked word in S_HOLD.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst,
   if_stage_if.master bus
);
   localparam int unsigned W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t       state;
   logic [W-1:0] pc;
   logic [W-1:0] kill_pc;
   logic [W-1:0] hold_inst;
   logic [W-1:0] ifid_inst;
   logic [W-1:0] ifid_pc4;
   logic         ifid_valid;
   logic         kill;
   logic         req;

   logic         advance;
   logic         redirect;
   logic [W-1:0] target;
   logic [W-1:0] pc_plus4;

   assign advance  = bus.pc__load & bus.IFID__Ld;
   assign redirect = advance & (bus.branch__taken | bus.jump);
   assign target   = bus.branch__taken ? bus.branch__target : bus.jump__target;
   assign pc_plus4 = pc + W'(4);

   // Fetch FSM, PC, kill tracking and IF/ID register in one sequential process.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         kill_pc    <= '0;
         hold_inst  <= '0;
         req        <= 1'b0;
         ifid_inst  <= NOP;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_FETCH;
               req   <= 1'b1;
            end

            S_FETCH: begin
               if (bus.imem__ack) begin
                  if (kill || redirect) begin
                     // Word belongs to the abandoned path; a fresh redirect beats the stored one.
                     pc   <= redirect ? target : kill_pc;
                     kill <= 1'b0;
                     if (bus.IFID__Ld) begin
                        ifid_inst  <= NOP;
                        ifid_pc4   <= '0;
                        ifid_valid <= 1'b0;
                     end
                  end else if (advance) begin
                     ifid_inst  <= bus.imem__rdata;
                     ifid_pc4   <= pc_plus4;
                     ifid_valid <= 1'b1;
                     pc         <= pc_plus4;
                  end else begin
                     hold_inst <= bus.imem__rdata;
                     state     <= S_HOLD;
                     req       <= 1'b0;
                  end
               end else if (redirect) begin
                  // Address must stay stable until ack, so remember where to go afterwards.
                  kill       <= 1'b1;
                  kill_pc    <= target;
                  ifid_inst  <= NOP;
                  ifid_pc4   <= '0;
                  ifid_valid <= 1'b0;
               end else if (advance) begin
                  ifid_inst  <= NOP;
                  ifid_pc4   <= '0;
                  ifid_valid <= 1'b0;
               end
            end

            S_HOLD: begin
               if (advance) begin
                  state <= S_FETCH;
                  req   <= 1'b1;
                  if (redirect) begin
                     pc         <= target;
                     ifid_inst  <= NOP;
                     ifid_pc4   <= '0;
                     ifid_valid <= 1'b0;
                  end else begin
                     pc         <= pc_plus4;
                     ifid_inst  <= hold_inst;
                     ifid_pc4   <= pc_plus4;
                     ifid_valid <= 1'b1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem__req   = req;
   assign bus.imem__addr  = pc;
   assign bus.IFID__inst  = ifid_inst;
   assign bus.IFID__pc4   = ifid_pc4;
   assign bus.IFID__valid = ifid_valid;
   assign bus.fetch__busy = (state == S_FETCH) & ~bus.imem__ack;
endmodule
